apb_mem_responder: RTL and testbench
====================================

# apb_mem_responder

APB3 completer that owns a local single-port memory and answers reads and writes issued by an APB requester. It is the responder end of the memory-access interface the team's benches drive: psel, penable and pwrite replace the cs/wr_rd_n pair. It adds three things on the memory side:
- programmable wait states;
- address-range error reporting;
- a hardware zero-fill sweep after reset, so memory contents are defined before the first transfer.

## Interface
- ADDR_WIDTH, 10, paddr width
- DATA_WIDTH, 8, pwdata/prdata width
- MEM_DEPTH, 1024, implemented words; must be ≤ 2**ADDR_WIDTH
- WAIT_STATES, 1, access cycles with pready low before completion (0..15)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- psel  in  1  transfer select
- penable  in  1  access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_WIDTH  word address
- pwdata  in  DATA_WIDTH  write data
- prdata  out  DATA_WIDTH  read data, registered
- pready  out  1  transfer completion, registered
- pslverr  out  1  error, valid only while pready=1
- init_done  out  1  zero-fill sweep complete

## Operation
- FSM states: ST_INIT, ST_IDLE, ST_WAIT, ST_READY.
- ST_INIT (entered on reset):
  - init counter steps 0..MEM_DEPTH-1 and writes 0 at one word per cycle.
  - After the last word, go to ST_IDLE and set init_done<=1.
  - APB inputs are ignored and pready stays 0.
- ST_IDLE, psel=1 (penable either value, so a transfer stalled by INIT is picked up):
  - WAIT_STATES=0 → ST_READY.
  - Otherwise → ST_WAIT, with the wait counter loaded to WAIT_STATES-1.
- ST_WAIT:
  - psel=0 (requester abort) → ST_IDLE with no memory write.
  - Counter=0 → ST_READY. Otherwise decrement.
- ST_READY:
  - pready=1 for exactly one cycle, then → ST_IDLE.
- Range error: paddr ≥ MEM_DEPTH → pslverr=1 with pready, write suppressed, prdata=0.
- Write: memory[paddr] <= pwdata at the clock edge that ends the ST_READY cycle, only when psel&penable&pwrite and there is no error.
- Read:
  - RAM is read with the current paddr on the edge entering ST_READY.
  - prdata is valid while pready=1 and holds until the next read completes.
  - Writes and errored reads do not change prdata, except that an errored read sets prdata=0.
- Reset mid-transfer: outputs return to reset values immediately, the transfer is lost, and the INIT sweep restarts.

## Timing
- Reset values: prdata=0, pready=0, pslverr=0, init_done=0, state=ST_INIT, counters=0.
- init_done rises MEM_DEPTH+1 clock edges after rst deasserts.
- Transfer length is setup + (WAIT_STATES+1) access cycles.
  - WAIT_STATES=0: pready high in the first access cycle.
  - WAIT_STATES=1: 3-cycle transfer.
- Back-to-back transfers: the next setup may arrive in the cycle after pready, with no idle cycle required.
- pready and pslverr are never asserted outside ST_READY.
- A read immediately after a write to the same address returns the new data.

## Structure
- apb_pkg:
  - state enum apb_resp_state_t (ST_INIT, ST_IDLE, ST_WAIT, ST_READY).
  - Constant WAIT_CNT_W=4.
- Sub-module sp_ram:
  - Single-port synchronous RAM with DATA_WIDTH/DEPTH parameters and ports clk, we, addr, wdata, rdata.
  - No reset on the array; the FSM drives its zero-fill.
- Address and write-data muxes select between the INIT counter and paddr/pwdata; they live in apb_mem_responder.

## Test plan
- Reset release, then read addresses 0, 511 and 1023 → init_done after 1025 edges; all reads return 8'h00 with pslverr=0.
- WAIT_STATES=1: write 0x3C to address 0x015, then read 0x015 → each transfer has pready high in its 2nd access cycle; prdata=8'h3C.
- Sweep all 1024 addresses with write(i, i[7:0]), then read them back → every word matches; back-to-back transfers with no idle cycles.
- MEM_DEPTH=768: write 0xAA to address 800, then read 800 → pslverr=1 with pready on both; prdata=0; addresses 0..767 unchanged.
- WAIT_STATES=3: drop psel during the 2nd wait cycle of a write of 0x55 to address 7 → no pready; a later read of address 7 returns 0x00.
- Assert rst during ST_WAIT of a write of 0x11 to address 2 → outputs 0 immediately, init_done=0, sweep restarts; a later read of address 2 returns 0x00.

Source files
------------

// File: rtl/apb_pkg.sv
// Purpose: shared types and constants for the APB memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_pkg;

    // Responder FSM states; ST_INIT owns the RAM until the zero-fill sweep ends.
    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } apb_resp_state_t;

    // Width of the wait-state counter (supports 0..15 wait states).
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/sp_ram.sv
// Purpose: single-port synchronous RAM, read-first, no reset on the array.
// Latency: read data registered, valid one edge after addr is presented.
// Backpressure: none; accepts a write or read every cycle.
// Ports: clk; we (write enable); addr (word address); wdata (write data);
//        rdata (registered read data of mem[addr] sampled at the last edge).
module sp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/apb_mem_responder.sv
// Purpose: APB3 completer fronting a local RAM, with zero-fill after reset.
// Latency: setup + (WAIT_STATES+1) access cycles per transfer; init takes MEM_DEPTH+1 edges.
// Backpressure: pready held low for WAIT_STATES access cycles and throughout the init sweep.
// Ports: clk, rst (async, active-high); psel/penable/pwrite/paddr/pwdata (APB request);
//        prdata/pready/pslverr (APB response, registered); init_done (zero-fill finished).
module apb_mem_responder
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  init_done
);

    // Init counter needs one extra count: it sits at MEM_DEPTH for one cycle
    // after the last word is written, which is the edge that leaves ST_INIT.
    localparam int                    INIT_W    = $clog2(MEM_DEPTH + 1);
    localparam logic [INIT_W-1:0]     INIT_LAST = INIT_W'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    apb_resp_state_t         state_q,     state_d;
    logic [INIT_W-1:0]       init_cnt_q,  init_cnt_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic                    pready_q,    pready_d;
    logic                    pslverr_q,   pslverr_d;
    logic                    init_done_q, init_done_d;
    logic [DATA_WIDTH-1:0]   prdata_q,    prdata_d;
    // rd_sel_q: the RAM output register holds this transfer's read data,
    // so prdata comes straight from it during ST_READY.
    logic                    rd_sel_q,    rd_sel_d;

    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic                    addr_err;
    logic                    go_ready;

    assign addr_err = ({1'b0, paddr} >= DEPTH_LIM);

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        init_done_d = init_done_q;
        prdata_d    = prdata_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        rd_sel_d    = 1'b0;
        go_ready    = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = paddr;
        ram_wdata   = pwdata;

        case (state_q)
            ST_INIT: begin
                ram_addr  = ADDR_WIDTH'(init_cnt_q);
                ram_wdata = '0;
                if (init_cnt_q == INIT_LAST) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    ram_we     = 1'b1;
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                // penable is not required: a request held through init is picked up here.
                if (psel) begin
                    if (WAIT_STATES == 0) begin
                        go_ready = 1'b1;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == '0) begin
                    go_ready = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
                ram_we  = psel && penable && pwrite && !pslverr_q;
                // Latch the read data so it holds after pready drops.
                if (rd_sel_q) begin
                    prdata_d = ram_rdata;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Entering ST_READY: RAM samples paddr on this same edge.
        if (go_ready) begin
            state_d   = ST_READY;
            pready_d  = 1'b1;
            pslverr_d = addr_err;
            if (!pwrite) begin
                if (addr_err) begin
                    prdata_d = '0;
                end else begin
                    rd_sel_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            init_done_q <= 1'b0;
            prdata_q    <= '0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            init_done_q <= init_done_d;
            prdata_q    <= prdata_d;
            rd_sel_q    <= rd_sel_d;
        end
    end

    sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Both sources are flops; the select is a flop too, so prdata stays glitch-free.
    assign prdata    = rd_sel_q ? ram_rdata : prdata_q;
    assign pready    = pready_q;
    assign pslverr   = pslverr_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_apb_mem_responder.sv
// Purpose: scoreboard bench for two responder configurations (default, and depth 768 / 3 wait states).
// Latency: n/a.
// Backpressure: driver waits on pready with a bounded cycle budget.
module tb_apb_mem_responder;

    typedef struct {
        bit         rd;
        bit         err;
        logic [7:0] data;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst;

    logic       psel_a, penable_a, pwrite_a;
    logic [9:0] paddr_a;
    logic [7:0] pwdata_a, prdata_a;
    logic       pready_a, pslverr_a, init_done_a;

    logic       psel_b, penable_b, pwrite_b;
    logic [9:0] paddr_b;
    logic [7:0] pwdata_b, prdata_b;
    logic       pready_b, pslverr_b, init_done_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    apb_mem_responder #(
        .ADDR_WIDTH(10), .DATA_WIDTH(8), .MEM_DEPTH(1024), .WAIT_STATES(1)
    ) dut_a (
        .clk(clk), .rst(rst), .psel(psel_a), .penable(penable_a), .pwrite(pwrite_a),
        .paddr(paddr_a), .pwdata(pwdata_a), .prdata(prdata_a), .pready(pready_a),
        .pslverr(pslverr_a), .init_done(init_done_a)
    );

    apb_mem_responder #(
        .ADDR_WIDTH(10), .DATA_WIDTH(8), .MEM_DEPTH(768), .WAIT_STATES(3)
    ) dut_b (
        .clk(clk), .rst(rst), .psel(psel_b), .penable(penable_b), .pwrite(pwrite_b),
        .paddr(paddr_b), .pwdata(pwdata_b), .prdata(prdata_b), .pready(pready_b),
        .pslverr(pslverr_b), .init_done(init_done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else pass_cnt++;
    endtask

    // Monitor: every completed transfer must match the oldest pending expectation.
    task automatic mon(input bit w, input logic err, input logic [7:0] d);
        exp_t e;
        total_cnt++;
        if ((w ? q_b.size() : q_a.size()) == 0) begin
            $display("FAIL unexpected_pready dut_%s: pslverr=%0b prdata=%h, expected no completion",
                     w ? "b" : "a", err, d);
        end else begin
            e = w ? q_b.pop_front() : q_a.pop_front();
            if (err !== e.err || (e.rd && d !== e.data))
                $display("FAIL dut_%s %s: pslverr=%0b prdata=%h, expected pslverr=%0b prdata=%h",
                         w ? "b" : "a", e.name, err, d, e.err, e.data);
            else pass_cnt++;
        end
    endtask

    always @(negedge clk) begin
        if (pready_a === 1'b1) mon(1'b0, pslverr_a, prdata_a);
        if (pready_b === 1'b1) mon(1'b1, pslverr_b, prdata_b);
    end

    task automatic drive(input bit w, input logic sel, input logic en, input logic wr,
                         input logic [9:0] a, input logic [7:0] d);
        if (w) begin
            psel_b = sel; penable_b = en; pwrite_b = wr; paddr_b = a; pwdata_b = d;
        end else begin
            psel_a = sel; penable_a = en; pwrite_a = wr; paddr_a = a; pwdata_a = d;
        end
    endtask

    // One full APB transfer; returns in the cycle where pready is high,
    // so the next call issues its setup with no idle cycle in between.
    task automatic xfer(input bit w, input bit wr, input logic [9:0] a, input logic [7:0] d,
                        input bit err, input logic [7:0] ed);
        exp_t e;
        int   cyc;
        e.rd = !wr; e.err = err; e.data = ed;
        e.name = $sformatf("%s_%0d", wr ? "wr" : "rd", a);
        if (w) q_b.push_back(e); else q_a.push_back(e);
        @(posedge clk); #1;
        drive(w, 1'b1, 1'b0, wr, a, d);
        @(posedge clk); #1;
        drive(w, 1'b1, 1'b1, wr, a, d);
        cyc = 1;
        while (((w ? pready_b : pready_a) !== 1'b1) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("access_cycles_%s", e.name), cyc, w ? 4 : 2);
    endtask

    task automatic idle(input bit w);
        @(posedge clk); #1;
        drive(w, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
    endtask

    // Release reset and count edges until each init_done rises.
    task automatic release_and_count(input bit do_a, input bit do_b);
        int na, nb;
        na = 0; nb = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 1100 && !((na != 0 || !do_a) && (nb != 0 || !do_b)); n++) begin
            @(posedge clk); #1;
            if (init_done_a === 1'b1 && na == 0) na = n;
            if (init_done_b === 1'b1 && nb == 0) nb = n;
        end
        if (do_a) chk("init_edges_a", na, 1025);
        if (do_b) chk("init_edges_b", nb, 769);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready_a",    pready_a,    0);
        chk("rst_pslverr_a",   pslverr_a,   0);
        chk("rst_prdata_a",    prdata_a,    0);
        chk("rst_init_done_a", init_done_a, 0);
        chk("rst_init_done_b", init_done_b, 0);
        release_and_count(1'b1, 1'b1);

        // Zero-filled memory on the default instance.
        xfer(1'b0, 1'b0, 10'd0,    8'h00, 1'b0, 8'h00);
        xfer(1'b0, 1'b0, 10'd511,  8'h00, 1'b0, 8'h00);
        xfer(1'b0, 1'b0, 10'd1023, 8'h00, 1'b0, 8'h00);
        // Write then read the same word.
        xfer(1'b0, 1'b1, 10'h015,  8'h3C, 1'b0, 8'h00);
        xfer(1'b0, 1'b0, 10'h015,  8'h00, 1'b0, 8'h3C);
        // Full back-to-back sweep.
        for (int i = 0; i < 1024; i++) xfer(1'b0, 1'b1, 10'(i), 8'(i), 1'b0, 8'h00);
        for (int i = 0; i < 1024; i++) xfer(1'b0, 1'b0, 10'(i), 8'h00, 1'b0, 8'(i));
        idle(1'b0);

        // Depth-768 instance: range errors.
        xfer(1'b1, 1'b1, 10'd767, 8'h5A, 1'b0, 8'h00);
        xfer(1'b1, 1'b0, 10'd767, 8'h00, 1'b0, 8'h5A);
        xfer(1'b1, 1'b1, 10'd800, 8'hAA, 1'b1, 8'h00);
        xfer(1'b1, 1'b0, 10'd800, 8'h00, 1'b1, 8'h00);
        xfer(1'b1, 1'b0, 10'd767, 8'h00, 1'b0, 8'h5A);
        xfer(1'b1, 1'b0, 10'd0,   8'h00, 1'b0, 8'h00);
        idle(1'b1);

        // Abort: psel dropped in the 2nd wait cycle of a write.
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 10'd7, 8'h55);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 10'd7, 8'h55);
        chk("abort_wait1_pready_b", pready_b, 0);
        @(posedge clk); #1;
        chk("abort_wait2_pready_b", pready_b, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        repeat (6) @(posedge clk);
        xfer(1'b1, 1'b0, 10'd7, 8'h00, 1'b0, 8'h00);
        idle(1'b1);

        // Reset in the middle of a write on the default instance.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 10'd2, 8'h11);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 10'd2, 8'h11);
        chk("midrst_pre_pready_a", pready_a, 0);
        chk("midrst_pre_prdata_a", prdata_a, 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_pready_a",    pready_a,    0);
        chk("midrst_prdata_a",    prdata_a,    0);
        chk("midrst_init_done_a", init_done_a, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        release_and_count(1'b1, 1'b0);
        xfer(1'b0, 1'b0, 10'd2, 8'h00, 1'b0, 8'h00);
        idle(1'b0);

        for (int n = 0; n < 20 && (q_a.size() != 0 || q_b.size() != 0); n++) @(posedge clk);
        chk("pending_a", q_a.size(), 0);
        chk("pending_b", q_b.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
